// File: rtl/pspin_cluster_seq_if.sv
// Control/status bundle between the host register block and the cluster boot sequencer.
// start_i/stop_i are single-cycle pulses; status outputs are level signals valid every cycle.
interface pspin_cluster_seq_if #(
    parameter int NUM_CLUSTERS  = 2,
    parameter int TIMEOUT_WIDTH = 32
);
    logic                     start_i;
    logic                     stop_i;
    logic [NUM_CLUSTERS-1:0]  cl_mask_i;
    logic [TIMEOUT_WIDTH-1:0] timeout_i;
    logic [NUM_CLUSTERS-1:0]  cl_eoc_i;
    logic [NUM_CLUSTERS-1:0]  cl_busy_i;
    logic                     aux_rst_o;
    logic [NUM_CLUSTERS-1:0]  cl_fetch_en_o;
    logic [2:0]               state_o;
    logic                     busy_o;
    logic                     done_o;
    logic                     timeout_o;
    logic [TIMEOUT_WIDTH-1:0] run_cycles_o;

    modport master (
        output start_i, stop_i, cl_mask_i, timeout_i, cl_eoc_i, cl_busy_i,
        input  aux_rst_o, cl_fetch_en_o, state_o, busy_o, done_o, timeout_o, run_cycles_o
    );

    modport slave (
        input  start_i, stop_i, cl_mask_i, timeout_i, cl_eoc_i, cl_busy_i,
        output aux_rst_o, cl_fetch_en_o, state_o, busy_o, done_o, timeout_o, run_cycles_o
    );
endinterface

// File: rtl/pspin_cluster_seq.sv
// Cluster boot/run sequencer: holds aux reset, staggers fetch enables over the selected
// clusters, then watches end-of-computation/busy until completion, timeout or stop.
module pspin_cluster_seq #(
    parameter int NUM_CLUSTERS     = 2,
    parameter int RST_HOLD_CYCLES  = 16,
    parameter int FETCH_GAP_CYCLES = 8,
    parameter int TIMEOUT_WIDTH    = 32
) (
    input logic                clk,
    input logic                rst,
    pspin_cluster_seq_if.slave bus
);
    localparam int NC = NUM_CLUSTERS;
    localparam int TW = TIMEOUT_WIDTH;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RESET = 3'd1;
    localparam logic [2:0] ST_WAKE  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int MAX_CNT = (RST_HOLD_CYCLES > FETCH_GAP_CYCLES) ? RST_HOLD_CYCLES : FETCH_GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(FETCH_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [NC-1:0]    NC_ONE    = NC'(1);
    localparam logic [TW:0]      RUN_ONE   = (TW+1)'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NC-1:0]    mask_q, mask_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [NC-1:0]    fetch_q, fetch_d;
    logic             aux_q, aux_d;
    logic [TW-1:0]    run_q, run_d;
    logic             tflag_q, tflag_d;
    logic             busy_q, done_q;
    logic [NC-1:0]    eoc_s1, eoc_s2, busy_s1, busy_s2;

    logic [NC-1:0]    pending, lowest;
    logic [TW:0]      run_inc;
    logic             all_done, timed_out;

    always_comb begin
        pending   = mask_q & ~fetch_q;
        lowest    = pending & (~pending + NC_ONE);
        all_done  = ((eoc_s2 & mask_q) == mask_q) && ((busy_s2 & mask_q) == '0);
        run_inc   = {1'b0, run_q} + RUN_ONE;
        // Compare one bit wider so a saturated counter cannot wrap past the limit.
        timed_out = (tmo_q != '0) && (run_inc >= {1'b0, tmo_q});

        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        tmo_d   = tmo_q;
        fetch_d = fetch_q;
        aux_d   = aux_q;
        run_d   = run_q;
        tflag_d = tflag_q;

        if (bus.stop_i) begin
            state_d = ST_IDLE;
            aux_d   = 1'b1;
            fetch_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i && (bus.cl_mask_i != '0)) begin
                        state_d = ST_RESET;
                        mask_d  = bus.cl_mask_i;
                        tmo_d   = bus.timeout_i;
                        run_d   = '0;
                        tflag_d = 1'b0;
                        cnt_d   = '0;
                        aux_d   = 1'b1;
                        fetch_d = '0;
                    end
                end
                ST_RESET: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAKE;
                        aux_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAKE: begin
                    if (fetch_q == mask_q) begin
                        state_d = ST_RUN;
                    end else if (cnt_q == GAP_LAST) begin
                        fetch_d = fetch_q | lowest;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    run_d = (&run_q) ? run_q : run_inc[TW-1:0];
                    // Completion is checked first so it wins over a same-cycle timeout.
                    if (all_done) begin
                        state_d = ST_DONE;
                        tflag_d = 1'b0;
                        aux_d   = 1'b1;
                        fetch_d = '0;
                    end else if (timed_out) begin
                        state_d = ST_DONE;
                        tflag_d = 1'b1;
                        aux_d   = 1'b1;
                        fetch_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    aux_d   = 1'b1;
                    fetch_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
            fetch_q <= '0;
            aux_q   <= 1'b1;
            run_q   <= '0;
            tflag_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eoc_s1  <= '0;
            eoc_s2  <= '0;
            busy_s1 <= '0;
            busy_s2 <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
            fetch_q <= fetch_d;
            aux_q   <= aux_d;
            run_q   <= run_d;
            tflag_q <= tflag_d;
            busy_q  <= (state_d == ST_RESET) || (state_d == ST_WAKE) || (state_d == ST_RUN);
            done_q  <= (state_d == ST_DONE);
            eoc_s1  <= bus.cl_eoc_i;
            eoc_s2  <= eoc_s1;
            busy_s1 <= bus.cl_busy_i;
            busy_s2 <= busy_s1;
        end
    end

    assign bus.aux_rst_o     = aux_q;
    assign bus.cl_fetch_en_o = fetch_q;
    assign bus.state_o       = state_q;
    assign bus.busy_o        = busy_q;
    assign bus.done_o        = done_q;
    assign bus.timeout_o     = tflag_q;
    assign bus.run_cycles_o  = run_q;
endmodule

// File: tb/tb_pspin_cluster_seq.sv
// Bench for pspin_cluster_seq: timing model derived from hold/gap arithmetic, randomized masks
// and timeouts, completion/timeout races, stop/start priority and asynchronous reset.
module tb_pspin_cluster_seq;
  localparam int NC   = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 8;
  localparam int TW   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pspin_cluster_seq_if #(.NUM_CLUSTERS(NC), .TIMEOUT_WIDTH(TW)) bus ();

  pspin_cluster_seq #(
    .NUM_CLUSTERS(NC), .RST_HOLD_CYCLES(HOLD), .FETCH_GAP_CYCLES(GAP), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int run_entry(input logic [NC-1:0] mask);
    return 1 + HOLD + $countones(mask) * GAP + 1;
  endfunction

  function automatic logic [NC-1:0] exp_fetch(input logic [NC-1:0] mask, input int c);
    int k = 0;
    logic [NC-1:0] f = '0;
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        k++;
        if (1 + HOLD + k * GAP <= c) f[i] = 1'b1;
      end
    end
    return f;
  endfunction

  function automatic logic [2:0] exp_state(input logic [NC-1:0] mask, input int c);
    if (c < 1 + HOLD) return 3'd1;
    if (c < run_entry(mask)) return 3'd2;
    return 3'd3;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start_i   = 1'b0;
    bus.stop_i    = 1'b0;
    bus.cl_mask_i = '0;
    bus.timeout_i = '0;
    bus.cl_eoc_i  = '0;
    bus.cl_busy_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drive_stop();
    bus.stop_i = 1'b1;
    tick();
    bus.stop_i   = 1'b0;
    bus.cl_eoc_i = '0;
    bus.cl_busy_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [NC+TW+6:0] got, exp;
    got = {bus.aux_rst_o, bus.cl_fetch_en_o, bus.state_o, bus.busy_o, bus.done_o, bus.timeout_o, bus.run_cycles_o};
    exp = {1'b1, {NC{1'b0}}, 3'd0, 1'b0, 1'b0, 1'b0, {TW{1'b0}}};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got, exp);
    end
  endtask

  // Starts a run and checks state/aux/fetch every cycle up to the first RUN cycle.
  task automatic test_boot(input logic [NC-1:0] mask, input logic [TW-1:0] to);
    int entry;
    logic [NC+3:0] got, exp;
    entry = run_entry(mask);
    bus.cl_mask_i = mask;
    bus.timeout_i = to;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
    bus.cl_mask_i = NC'($urandom);
    bus.timeout_i = $urandom;
    for (int c = 1; c <= entry; c++) begin
      exp = {exp_state(mask, c), (c < 1 + HOLD), exp_fetch(mask, c)};
      got = {bus.state_o, bus.aux_rst_o, bus.cl_fetch_en_o};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL boot mask=%b c=%0d: got %h expected %h", mask, c, got, exp);
      end
      if (c < entry) tick();
    end
    n_checks++;
    if (bus.run_cycles_o !== '0 || bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry_counters: got run=%0d busy=%b expected run=0 busy=1", bus.run_cycles_o, bus.busy_o);
    end
  endtask

  task automatic test_completion();
    int r;
    r = $urandom_range(0, 20);
    test_boot(2'b11, '0);
    repeat (r) tick();
    bus.cl_eoc_i  = 2'b11;
    bus.cl_busy_i = 2'b00;
    tick();
    tick();
    n_checks++;
    if (bus.done_o !== 1'b0 || bus.state_o !== 3'd3) begin
      n_fail++;
      $display("FAIL completion_early: got done=%b state=%0d expected done=0 state=3", bus.done_o, bus.state_o);
    end
    tick();
    n_checks++;
    if ({bus.done_o, bus.state_o, bus.timeout_o, bus.aux_rst_o, bus.cl_fetch_en_o, bus.busy_o} !== {1'b1, 3'd4, 1'b0, 1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL completion_done: got done=%b state=%0d to=%b aux=%b fetch=%b busy=%b expected 1 4 0 1 00 0",
               bus.done_o, bus.state_o, bus.timeout_o, bus.aux_rst_o, bus.cl_fetch_en_o, bus.busy_o);
    end
    n_checks++;
    if (bus.run_cycles_o !== TW'(r + 3)) begin
      n_fail++;
      $display("FAIL completion_run_cycles: got %0d expected %0d", bus.run_cycles_o, r + 3);
    end
    repeat (4) tick();
    n_checks++;
    if (bus.run_cycles_o !== TW'(r + 3) || bus.state_o !== 3'd4) begin
      n_fail++;
      $display("FAIL done_frozen: got run=%0d state=%0d expected run=%0d state=4", bus.run_cycles_o, bus.state_o, r + 3);
    end
    drive_stop();
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.run_cycles_o !== TW'(r + 3) || bus.aux_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_from_done: got state=%0d run=%0d aux=%b expected state=0 run=%0d aux=1",
               bus.state_o, bus.run_cycles_o, bus.aux_rst_o, r + 3);
    end
  endtask

  task automatic test_busy_block();
    test_boot(2'b11, '0);
    bus.cl_eoc_i  = 2'b11;
    bus.cl_busy_i = 2'b01;
    repeat (10) tick();
    n_checks++;
    if (bus.done_o !== 1'b0 || bus.state_o !== 3'd3) begin
      n_fail++;
      $display("FAIL busy_blocks: got done=%b state=%0d expected done=0 state=3", bus.done_o, bus.state_o);
    end
    bus.cl_busy_i = 2'b00;
    tick();
    tick();
    n_checks++;
    if (bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_drop_early: got done=%b expected 0", bus.done_o);
    end
    tick();
    n_checks++;
    if (bus.done_o !== 1'b1 || bus.timeout_o !== 1'b0 || bus.run_cycles_o !== TW'(13)) begin
      n_fail++;
      $display("FAIL busy_drop_done: got done=%b to=%b run=%0d expected 1 0 13", bus.done_o, bus.timeout_o, bus.run_cycles_o);
    end
    drive_stop();
  endtask

  // Leaves the DUT in DONE after a timeout.
  task automatic test_timeout(input logic [NC-1:0] mask, input int to);
    logic [TW-1:0] exp_run;
    exp_q.push_back(TW'(to));
    test_boot(mask, TW'(to));
    repeat (to - 1) tick();
    n_checks++;
    if (bus.state_o !== 3'd3 || bus.run_cycles_o !== TW'(to - 1)) begin
      n_fail++;
      $display("FAIL timeout_early to=%0d: got state=%0d run=%0d expected state=3 run=%0d", to, bus.state_o, bus.run_cycles_o, to - 1);
    end
    tick();
    exp_run = exp_q.pop_front();
    n_checks++;
    if ({bus.state_o, bus.done_o, bus.timeout_o} !== {3'd4, 1'b1, 1'b1} || bus.run_cycles_o !== exp_run) begin
      n_fail++;
      $display("FAIL timeout_done to=%0d: got state=%0d done=%b to=%b run=%0d expected 4 1 1 run=%0d",
               to, bus.state_o, bus.done_o, bus.timeout_o, bus.run_cycles_o, exp_run);
    end
  endtask

  task automatic test_same_cycle();
    int to;
    to = $urandom_range(3, 50);
    test_boot(2'b11, TW'(to));
    repeat (to - 3) tick();
    bus.cl_eoc_i = 2'b11;
    tick();
    tick();
    n_checks++;
    if (bus.state_o !== 3'd3) begin
      n_fail++;
      $display("FAIL race_early to=%0d: got state=%0d expected 3", to, bus.state_o);
    end
    tick();
    n_checks++;
    if (bus.state_o !== 3'd4 || bus.timeout_o !== 1'b0 || bus.run_cycles_o !== TW'(to)) begin
      n_fail++;
      $display("FAIL race_completion_wins to=%0d: got state=%0d to=%b run=%0d expected 4 0 %0d",
               to, bus.state_o, bus.timeout_o, bus.run_cycles_o, to);
    end
    drive_stop();
  endtask

  task automatic test_stop_retains();
    n_checks++;
    drive_stop();
    if (bus.state_o !== 3'd0 || bus.timeout_o !== 1'b1 || bus.run_cycles_o !== TW'(100)) begin
      n_fail++;
      $display("FAIL stop_retains: got state=%0d to=%b run=%0d expected 0 1 100", bus.state_o, bus.timeout_o, bus.run_cycles_o);
    end
  endtask

  task automatic test_stop_start_wake();
    bus.cl_mask_i = 2'b11;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (1 + HOLD + GAP + 1) tick();
    n_checks++;
    if (bus.state_o !== 3'd2 || bus.cl_fetch_en_o !== 2'b01) begin
      n_fail++;
      $display("FAIL wake_midway: got state=%0d fetch=%b expected 2 01", bus.state_o, bus.cl_fetch_en_o);
    end
    bus.stop_i  = 1'b1;
    bus.start_i = 1'b1;
    tick();
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    n_checks++;
    if ({bus.state_o, bus.aux_rst_o, bus.cl_fetch_en_o, bus.busy_o} !== {3'd0, 1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL stop_beats_start: got state=%0d aux=%b fetch=%b busy=%b expected 0 1 00 0",
               bus.state_o, bus.aux_rst_o, bus.cl_fetch_en_o, bus.busy_o);
    end
  endtask

  task automatic test_start_in_run();
    test_boot(2'b01, '0);
    repeat (5) tick();
    bus.cl_mask_i = 2'b11;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n_checks++;
    if (bus.state_o !== 3'd3 || bus.run_cycles_o !== TW'(6) || bus.cl_fetch_en_o !== 2'b01) begin
      n_fail++;
      $display("FAIL start_in_run: got state=%0d run=%0d fetch=%b expected 3 6 01", bus.state_o, bus.run_cycles_o, bus.cl_fetch_en_o);
    end
    drive_stop();
  endtask

  task automatic test_start_from_done();
    test_timeout(2'b01, $urandom_range(5, 30));
    bus.cl_mask_i = 2'b10;
    bus.timeout_i = '0;
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    n_checks++;
    if ({bus.state_o, bus.done_o, bus.timeout_o, bus.aux_rst_o, bus.busy_o} !== {3'd1, 1'b0, 1'b0, 1'b1, 1'b1} || bus.run_cycles_o !== '0) begin
      n_fail++;
      $display("FAIL restart_from_done: got state=%0d done=%b to=%b aux=%b busy=%b run=%0d expected 1 0 0 1 1 0",
               bus.state_o, bus.done_o, bus.timeout_o, bus.aux_rst_o, bus.busy_o, bus.run_cycles_o);
    end
    drive_stop();
  endtask

  task automatic test_zero_mask();
    bus.cl_mask_i = '0;
    bus.timeout_i = TW'(5);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (bus.state_o !== 3'd0 || bus.busy_o !== 1'b0 || bus.aux_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_mask: got state=%0d busy=%b aux=%b expected 0 0 1", bus.state_o, bus.busy_o, bus.aux_rst_o);
    end
  endtask

  task automatic test_reset_mid_run();
    test_boot(2'b11, '0);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.aux_rst_o, bus.cl_fetch_en_o, bus.state_o, bus.run_cycles_o} !== {1'b1, 2'b00, 3'd0, {TW{1'b0}}}) begin
      n_fail++;
      $display("FAIL async_reset: got aux=%b fetch=%b state=%0d run=%0d expected 1 00 0 0",
               bus.aux_rst_o, bus.cl_fetch_en_o, bus.state_o, bus.run_cycles_o);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_boot(2'b11, '0);
    drive_stop();
    test_boot(2'b10, '0);
    drive_stop();
    for (int i = 0; i < 3; i++) begin
      test_boot(NC'($urandom_range(1, 3)), '0);
      drive_stop();
    end
    test_completion();
    test_busy_block();
    test_timeout(2'b11, 100);
    test_stop_retains();
    for (int i = 0; i < 3; i++) begin
      test_timeout(NC'($urandom_range(1, 3)), $urandom_range(1, 60));
      drive_stop();
    end
    test_same_cycle();
    test_stop_start_wake();
    test_start_in_run();
    test_start_from_done();
    test_zero_mask();
    test_reset_mid_run();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pspin_cluster_seq.md
# pspin_cluster_seq

Boot/run sequencer for the PsPIN cluster array. It holds the aux reset, releases it after a fixed hold time, then enables instruction fetch on each selected cluster in index order with a fixed gap between clusters. It then monitors end-of-computation and busy until the run completes, times out or is stopped. It sits between the host-facing control registers (start/stop/mask/timeout, status readback) and the cluster `fetch_en`/aux reset pins.

## Interface
- `NUM_CLUSTERS`, 2, number of clusters (1..32)
- `RST_HOLD_CYCLES`, 16, cycles `aux_rst_o` stays high after start (≥1)
- `FETCH_GAP_CYCLES`, 8, cycles between successive fetch enables (≥1)
- `TIMEOUT_WIDTH`, 32, width of timeout and run counter
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-high
- `start_i` in 1: one-cycle start pulse
- `stop_i` in 1: one-cycle abort pulse
- `cl_mask_i` in NUM_CLUSTERS: clusters to run; latched on accepted start
- `timeout_i` in TIMEOUT_WIDTH: run-cycle limit; 0 = disabled; latched on accepted start
- `cl_eoc_i` in NUM_CLUSTERS: cluster end-of-computation; asynchronous
- `cl_busy_i` in NUM_CLUSTERS: cluster busy; asynchronous
- `aux_rst_o` out 1: cluster reset, high = reset
- `cl_fetch_en_o` out NUM_CLUSTERS: per-cluster fetch enable
- `state_o` out 3: IDLE=0, RESET=1, WAKE=2, RUN=3, DONE=4
- `busy_o` out 1: high in RESET, WAKE and RUN
- `done_o` out 1: high in DONE
- `timeout_o` out 1: DONE was reached by timeout
- `run_cycles_o` out TIMEOUT_WIDTH: cycles spent in RUN

## Operation
- Reset values: `aux_rst_o`=1, `cl_fetch_en_o`=0, `state_o`=IDLE, `busy_o`=0, `done_o`=0, `timeout_o`=0, `run_cycles_o`=0. All outputs are registered.
- `cl_eoc_i` and `cl_busy_i` each pass through a 2-flop synchronizer. All decisions use the synced values.
- IDLE: `aux_rst_o`=1, fetch enables are 0.
  - `start_i` with nonzero `cl_mask_i`: latch mask and timeout, clear `run_cycles_o`, `timeout_o`, then go to RESET.
  - `start_i` with zero mask is ignored.
- RESET: `aux_rst_o`=1. After RST_HOLD_CYCLES cycles in RESET, go to WAKE.
- WAKE: `aux_rst_o`=0.
  - A gap counter counts FETCH_GAP_CYCLES.
  - At expiry, the lowest-index masked cluster not yet enabled gets its `cl_fetch_en_o` bit set, and the gap counter restarts.
  - After the highest masked cluster is enabled, go to RUN on the next cycle.
  - Unmasked bits stay 0 throughout.
- RUN: `run_cycles_o` increments every cycle, saturating at all-ones.
  - Completion: (eoc_sync & mask)==mask and (busy_sync & mask)==0. Go to DONE, `timeout_o`=0.
  - Timeout: `timeout_i`≠0 and `run_cycles_o`+1 ≥ latched timeout. Go to DONE, `timeout_o`=1.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE: `aux_rst_o`=1, fetch enables are 0, `run_cycles_o` and `timeout_o` are frozen.
  - `start_i` restarts exactly as from IDLE.
  - `stop_i` goes to IDLE.
- `stop_i` in any state: next state is IDLE, `aux_rst_o`=1, fetch enables are 0, `timeout_o` and `run_cycles_o` are retained. `stop_i` wins over a simultaneous `start_i`.
- `start_i` in RESET, WAKE or RUN is ignored. `start_i` in IDLE and DONE follows the rules above.
- Mask and timeout inputs are ignored except on an accepted start.
- Async reset mid-run: all outputs return to reset values immediately. `aux_rst_o` asserts without waiting for a clock edge.

## Timing
- Start sampled at edge T. `state_o`=RESET from T+1. `aux_rst_o` falls at T+1+RST_HOLD_CYCLES (WAKE entry, W).
- The k-th masked cluster (k=1..n) gets fetch enable at W+k·FETCH_GAP_CYCLES. RUN is entered one cycle after the last enable.
- Completion latency: a masked input edge updates the synced values 2 cycles later. DONE follows 1 cycle after that, so 3 cycles from `cl_eoc_i` rise to `done_o` rise.
- Stop latency: 1 cycle from `stop_i` to IDLE and outputs.
- `run_cycles_o` reads 0 in the first RUN cycle. It reads N in the cycle after N RUN cycles.

## Test plan
- Basic boot. Reset, then mask=2'b11, timeout=0, start at T. Required: `aux_rst_o` falls at T+17. `cl_fetch_en_o` = 01 at T+25 and 11 at T+33. `state_o`=RUN at T+34.
- Sparse mask. mask=2'b10. Required: bit0 never set, bit1 set at T+25, RUN at T+26.
- Completion.
  - In RUN, raise `cl_eoc_i`=11 with `cl_busy_i`=00. Required: `done_o`=1 three cycles later, `timeout_o`=0, `aux_rst_o`=1, fetch enables 0, `run_cycles_o` frozen.
  - Holding busy=01 blocks DONE until busy drops.
- Timeout. timeout=100, eoc never asserted. Required: DONE with `timeout_o`=1 and `run_cycles_o`=100.
  - Repeat with eoc arriving so completion and timeout fall in the same cycle. Required: `timeout_o`=0.
- Stop/start priority.
  - `stop_i` and `start_i` together in WAKE. Required: IDLE next cycle.
  - `start_i` in RUN is ignored.
  - `start_i` from DONE re-enters RESET and clears the counters.
- Zero mask and reset mid-run.
  - Start with mask=0. Required: stays IDLE.
  - Assert `rst` in RUN between edges. Required: `aux_rst_o`=1 and `cl_fetch_en_o`=0 immediately.
